// File: rtl/user_pkg.sv
// Shared audio types for the I2S receiver and the downstream filter stage.
package user_pkg;
  localparam int AuSampleWidth = 16;

  typedef enum logic {
    AuLeft  = 1'b0,
    AuRight = 1'b1
  } au_chan_e;

  typedef struct packed {
    au_chan_e                 chan;
    logic [AuSampleWidth-1:0] data;
  } au_sample_t;
endpackage

// File: rtl/user_au_sample_fifo.sv
// Small fall-through FIFO of au_sample_t words; head is visible whenever non-empty.
module user_au_sample_fifo
  import user_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  au_sample_t data_i,
  input  logic       pop_i,
  output au_sample_t data_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  au_sample_t    mem_q [Depth];
  au_sample_t    mem_d [Depth];
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts push+pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/user_au_i2s_rx.sv
// I2S receiver: deserialises stereo words on SCK rising edges and queues them
// as {channel, sample} for the filter stage, with sticky overflow/frame flags.
module user_au_i2s_rx
  import user_pkg::*;
#(
  parameter int SampleWidth = AuSampleWidth,
  parameter int FifoDepth   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   sck_i,
  input  logic                   ws_i,
  input  logic                   sd_i,
  output logic [SampleWidth-1:0] sample_o,
  output logic                   chan_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   overflow_o,
  output logic                   frame_err_o,
  input  logic                   clr_i
);
  localparam int CW = $clog2(SampleWidth + 1);
  localparam logic [CW-1:0] SwCnt = CW'(SampleWidth);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SYNCED = 1'b1;

  logic                   sck_q, sck_d;
  logic                   ws_prev_q, ws_prev_d;
  logic [0:0]             state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SampleWidth-1:0] shreg_q, shreg_d;
  logic                   ovf_q, ovf_d, ferr_q, ferr_d;
  logic                   rise, push, pop, ferr_set, ovf_set;
  logic                   full, empty;
  au_sample_t             push_word, head;

  assign rise = sck_i & ~sck_q;

  always_comb begin
    sck_d     = sck_i;
    ws_prev_d = ws_prev_q;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    if (!en_i) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (rise) begin
      // The bit on a WS-change rise still belongs to the closing slot (1-bit I2S delay).
      if (bit_cnt_q < SwCnt) begin
        shreg_d   = {shreg_q[SampleWidth-2:0], sd_i};
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
      if (ws_i != ws_prev_q) begin
        if (state_q == SYNCED) begin
          if (bit_cnt_d == SwCnt) push = 1'b1;
          else                    ferr_set = 1'b1;
        end
        bit_cnt_d = '0;
        state_d   = SYNCED;
        ws_prev_d = ws_i;
      end
    end
  end

  assign push_word.chan = au_chan_e'(ws_prev_q);
  assign push_word.data = shreg_d;

  assign pop     = ready_i & ~empty;
  assign ovf_set = push & full & ~pop;
  // Setting wins over a simultaneous clear.
  assign ovf_d   = (ovf_q & ~clr_i) | ovf_set;
  assign ferr_d  = (ferr_q & ~clr_i) | ferr_set;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q     <= 1'b0;
      ws_prev_q <= 1'b0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sck_q     <= sck_d;
      ws_prev_q <= ws_prev_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
    end
  end

  user_au_sample_fifo #(.Depth(FifoDepth)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_word),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign sample_o    = head.data;
  assign chan_o      = head.chan;
  assign valid_o     = ~empty;
  assign overflow_o  = ovf_q;
  assign frame_err_o = ferr_q;
endmodule

// File: tb/tb_user_au_i2s_rx.sv
// Directed/randomised bench for user_au_i2s_rx against a slot-level bit-queue model.
module tb_user_au_i2s_rx;
  logic        clk, rst_i, en_i, sck_i, ws_i, sd_i, ready_i, clr_i;
  logic [15:0] sample_o;
  logic        chan_o, valid_o, overflow_o, frame_err_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [16:0] exp_q[$];
  logic        bits_q[$];
  logic        m_synced, m_wsprev, m_ovf, m_ferr;
  logic        cur_ch, v_before, v_after;
  logic [31:0] val;

  user_au_i2s_rx dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
    .sample_o(sample_o), .chan_o(chan_o), .valid_o(valid_o), .ready_i(ready_i),
    .overflow_o(overflow_o), .frame_err_o(frame_err_o), .clr_i(clr_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    if (exp_q.size() > 0) begin
      check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
      check({tag, "_sample"}, {16'd0, sample_o}, {16'd0, exp_q[0][15:0]});
      check({tag, "_chan"}, {31'd0, chan_o}, {31'd0, exp_q[0][16]});
    end else begin
      check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    end
    check({tag, "_ovf"}, {31'd0, overflow_o}, {31'd0, m_ovf});
    check({tag, "_ferr"}, {31'd0, frame_err_o}, {31'd0, m_ferr});
  endtask

  function automatic void m_push(input logic c, input logic [15:0] d);
    if (exp_q.size() < 4) exp_q.push_back({c, d});
    else m_ovf = 1'b1;
  endfunction

  // Slots are the bit runs between WS changes; a complete slot keeps its first 16 bits.
  function automatic void model_rise(input logic w, input logic d);
    logic [15:0] word;
    bits_q.push_back(d);
    if (w != m_wsprev) begin
      if (m_synced) begin
        if (bits_q.size() >= 16) begin
          word = '0;
          for (int i = 0; i < 16; i++) word = {word[14:0], bits_q[i]};
          m_push(m_wsprev, word);
        end else begin
          m_ferr = 1'b1;
        end
      end
      bits_q.delete();
      m_synced = 1'b1;
      m_wsprev = w;
    end
  endfunction

  task automatic set_en(input logic v);
    en_i = v;
    if (!v) begin
      m_synced = 1'b0;
      bits_q.delete();
    end
  endtask

  // One SCK period of 8 clocks; optional ready/clr pulse coincides with the rise cycle.
  task automatic do_rise(input logic w, input logic d, input logic rdy, input logic clr);
    sck_i = 1'b0; ws_i = w; sd_i = d;
    repeat (4) @(negedge clk);
    v_before = valid_o;
    sck_i = 1'b1; ready_i = rdy; clr_i = clr;
    if (clr) begin m_ovf = 1'b0; m_ferr = 1'b0; end
    if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (en_i) model_rise(w, d);
    @(negedge clk);
    ready_i = 1'b0; clr_i = 1'b0;
    v_after = valid_o;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_slot(input logic c, input logic [31:0] v, input int n,
                           input logic rdy_end, input logic clr_end);
    for (int i = 0; i < n; i++)
      do_rise((i == n-1) ? ~c : c, v[n-1-i], rdy_end && (i == n-1), clr_end && (i == n-1));
    cur_ch = ~c;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    m_ovf = 1'b0; m_ferr = 1'b0;
    @(negedge clk);
    clr_i = 1'b0;
  endtask

  task automatic pop_one(input string tag);
    check_state(tag);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic drain(input string tag);
    int budget = 8;
    while (exp_q.size() > 0 && budget > 0) begin
      pop_one(tag);
      budget--;
    end
    check({tag, "_empty"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    logic [15:0] last_word;
    rst_i = 1'b1;
    en_i = 1'($urandom); sck_i = 1'($urandom); ws_i = 1'($urandom);
    sd_i = 1'($urandom); ready_i = 1'($urandom); clr_i = 1'($urandom);
    m_synced = 1'b0; m_wsprev = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0; cur_ch = 1'b0;
    v_before = 1'b0; v_after = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sample", {16'd0, sample_o}, 32'd0);
    check("rst_chan", {31'd0, chan_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_ovf", {31'd0, overflow_o}, 32'd0);
    check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    rst_i = 1'b0; en_i = 1'b0; sck_i = 1'b0; ws_i = 1'b0; ready_i = 1'b0; clr_i = 1'b0;
    @(negedge clk);

    // Disabled receiver ignores SCK traffic
    for (int i = 0; i < 10; i++) do_rise(1'($urandom), 1'($urandom), 1'b0, 1'b0);
    check_state("dis");

    // Sync, then stereo stream with latency check on the first stored word
    set_en(1'b1);
    send_slot(1'b0, $urandom, 16, 1'b0, 1'b0);
    check_state("sync");
    send_slot(1'b1, $urandom, 16, 1'b0, 1'b0);
    check("lat_before", {31'd0, v_before}, 32'd0);
    check("lat_after", {31'd0, v_after}, 32'd1);
    send_slot(1'b0, 32'h0000_A5C3, 16, 1'b0, 1'b0);
    send_slot(1'b1, 32'h0000_1234, 16, 1'b0, 1'b0);
    check_state("stereo");
    pop_one("pop_r0");
    check("l_sample", {16'd0, sample_o}, 32'h0000_A5C3);
    check("l_chan", {31'd0, chan_o}, 32'd0);
    pop_one("pop_l");
    check("r_sample", {16'd0, sample_o}, 32'h0000_1234);
    check("r_chan", {31'd0, chan_o}, 32'd1);
    pop_one("pop_r");
    check("stereo_empty", {31'd0, valid_o}, 32'd0);

    // Long 24-bit slot keeps its 16 MSBs
    send_slot(1'b0, 32'h00AB_CDEF, 24, 1'b0, 1'b0);
    check("long_sample", {16'd0, sample_o}, 32'h0000_ABCD);
    check("long_chan", {31'd0, chan_o}, 32'd0);
    check("long_ferr", {31'd0, frame_err_o}, 32'd0);
    send_slot(1'b1, $urandom, 16, 1'b0, 1'b0);
    drain("long");

    // Short slot -> frame error; clear; clear coinciding with a new short word
    send_slot(1'b0, $urandom, 10, 1'b0, 1'b0);
    check_state("short");
    check("short_ferr", {31'd0, frame_err_o}, 32'd1);
    pulse_clr();
    check("clr_ferr", {31'd0, frame_err_o}, 32'd0);
    send_slot(1'b1, $urandom, 10, 1'b0, 1'b1);
    check("clrset_ferr", {31'd0, frame_err_o}, 32'd1);
    check_state("clrset");
    pulse_clr();
    send_slot(cur_ch, $urandom, 16, 1'b0, 1'b0);
    drain("realign");

    // Overflow with ready low, then push+pop on a full FIFO
    for (int i = 0; i < 5; i++) send_slot(cur_ch, $urandom, 16, 1'b0, 1'b0);
    check("ovf_set", {31'd0, overflow_o}, 32'd1);
    check_state("ovf");
    pulse_clr();
    send_slot(cur_ch, $urandom, 16, 1'b1, 1'b0);
    check("pp_ovf", {31'd0, overflow_o}, 32'd0);
    check_state("pp");
    drain("pp");

    // Enable dropped mid-word: partial discarded, first boundary only re-syncs
    for (int i = 0; i < 8; i++) do_rise(cur_ch, 1'($urandom), 1'b0, 1'b0);
    set_en(1'b0);
    repeat (10) @(negedge clk);
    set_en(1'b1);
    send_slot(cur_ch, $urandom, 16, 1'b0, 1'b0);
    check_state("resync");
    val = $urandom;
    last_word = val[15:0];
    send_slot(cur_ch, val, 16, 1'b0, 1'b0);
    check("reen_sample", {16'd0, sample_o}, {16'd0, last_word});
    check_state("reen");
    drain("reen");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/user_au_i2s_rx.md
Name: user_au_i2s_rx

Overview:
- I2S receiver directly upstream of the user audio filter block.
- Deserialises stereo PCM from synchronised GPIO pins (SCK, WS, SD).
- Buffers {channel, sample} words in a small FIFO.
- Presents them on a valid/ready stream consumed by the filter stage; sticky error flags exported for status/interrupt use.

Parameters:
- SampleWidth, 16, bits per stored sample; MSB-first, extra slot bits ignored.
- FifoDepth, 4, FIFO entries (power of two, >=2).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  receiver enable
- sck_i  in  1  I2S bit clock (already synchronised to clk_i)
- ws_i  in  1  word select, 0=left 1=right (synchronised)
- sd_i  in  1  serial data (synchronised)
- sample_o  out  SampleWidth  head-of-FIFO sample
- chan_o  out  1  channel of head sample
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer accepts head when valid_o&ready_i
- overflow_o  out  1  sticky: word dropped, FIFO full
- frame_err_o  out  1  sticky: short word (<SampleWidth bits) between boundaries
- clr_i  in  1  clears both sticky flags

Behaviour:
- Reset (rst_i sampled high at clk_i edge): sck_q=0, ws_prev=0, synced=0, bit_cnt=0, shreg=0, FIFO empty, storage zeroed. Outputs: sample_o=0, chan_o=0, valid_o=0, overflow_o=0, frame_err_o=0.
- Edge detect: rise = sck_i & ~sck_q; sck_q registered every cycle. All protocol action occurs only in rise cycles with en_i=1.
- Shift, every rise: if bit_cnt<SampleWidth then shreg={shreg[SW-2:0],sd_i} and bit_cnt++; else the bit is ignored. bit_cnt saturates at SampleWidth.
- Boundary: a rise with ws_i!=ws_prev. The sd_i bit sampled at this rise is the LSB of the previous slot (standard I2S 1-bit delay) and is shifted first. Then:
  - if synced and bit_cnt==SW (post-shift): push {ws_prev, shreg};
  - if synced and bit_cnt<SW: no push, frame_err_o<=1;
  - in all boundary cases: bit_cnt<=0, synced<=1, ws_prev<=ws_i.
- First boundary after reset/enable only synchronises; it never pushes and never flags an error.
- en_i=0: synced<=0, bit_cnt<=0, no shifting. FIFO content is kept and stays drainable. Deasserting mid-word discards the partial word.
- FIFO: synchronous, fall-through head. valid_o=!empty; sample_o/chan_o show the head entry.
- Latency: word pushed in boundary-rise cycle N gives valid_o=1 from cycle N+1.
- Pop on valid_o&ready_i. Order strictly preserved across channels.
- Full FIFO:
  - push with no pop: new word dropped, overflow_o<=1;
  - push and pop in the same cycle: push accepted, no overflow.
- Empty FIFO: ready_i ignored; pointers never move.
- Sticky flags: a set in the same cycle as clr_i wins (flag stays 1).
- Pointer wrap: log2(FifoDepth)-bit read/write pointers plus a count register; count range 0..FifoDepth.

Decomposition:
- user_pkg additions:
  - AuSampleWidth constant (default 16, shared with the filter stage);
  - au_chan_e enum {AuLeft=0, AuRight=1};
  - au_sample_t struct {au_chan_e chan; logic [AuSampleWidth-1:0] data}.
- One natural sub-module: user_au_sample_fifo, a parameterised au_sample_t FIFO with push/pop/full/empty, synchronous active-high reset.
- The I2S front end (edge detect, shreg, bit_cnt, sync FSM IDLE/SYNCED) stays in user_au_i2s_rx.

Test Plan:
- Reset: hold rst_i 2 cycles with random pins -> all outputs 0. Toggle sck_i for 10 cycles with en_i=0 -> valid_o stays 0.
- Basic stereo (SCK period 8 clk, slot 16, SW=16): first boundary, then L=16'hA5C3, R=16'h1234 -> pops (0,A5C3) then (1,1234). valid_o rises 1 cycle after each closing boundary rise.
- Long slot 24 bits: L=24'hABCDEF -> sample_o=16'hABCD, chan_o=0, frame_err_o=0.
- Short slot 10 bits between boundaries -> no push, frame_err_o=1. Pulse clr_i -> 0. Drive clr_i in the same cycle as a new short word -> flag stays 1.
- ready_i=0, 5 words, FifoDepth=4 -> first 4 retained, overflow_o=1. Raise ready_i -> the 4 drain in order, valid_o=0 after. Full FIFO with simultaneous pop+push -> no overflow.
- en_i dropped after 8 bits of a word, re-raised -> partial word discarded. First boundary after re-enable pushes nothing; the next complete word is received correctly.
